regstat_rf: RTL and testbench

//  Architectural register file plus per-register rename status (pending bit + ROB tag).

---
 rtl/regstat_rf_if.sv | 44 ++++
 rtl/regstat_rf.sv | 124 ++++++++++++
 tb/tb_regstat_rf.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/regstat_rf_if.sv
// Rename/retire/bypass bus between decode, the ROB and the register status file.
// The master modport is the decode/ROB side and the slave modport is the register file.
interface regstat_rf_if #(
  parameter int DATAW    = 32,
  parameter int REGADDRW = 5,
  parameter int TAGW     = 6
);
  logic                rd_en;
  logic [REGADDRW-1:0] rs1_addr;
  logic [REGADDRW-1:0] rs2_addr;
  logic                rs1_ready;
  logic [DATAW-1:0]    rs1_value;
  logic [TAGW-1:0]     rs1_tag;
  logic                rs2_ready;
  logic [DATAW-1:0]    rs2_value;
  logic [TAGW-1:0]     rs2_tag;
  logic                alloc;
  logic [REGADDRW:0]   alloc_dst_reg;
  logic [TAGW-1:0]     alloc_tag;
  logic                retiring;
  logic [REGADDRW:0]   retiring_dst_reg;
  logic [TAGW-1:0]     retiring_tag;
  logic [DATAW-1:0]    retiring_value;
  logic                incoming_en;
  logic [TAGW-1:0]     incoming_tag;
  logic [DATAW-1:0]    incoming_value;
  logic                flush;

  modport master (
    output rd_en, rs1_addr, rs2_addr,
    output alloc, alloc_dst_reg, alloc_tag,
    output retiring, retiring_dst_reg, retiring_tag, retiring_value,
    output incoming_en, incoming_tag, incoming_value, flush,
    input  rs1_ready, rs1_value, rs1_tag, rs2_ready, rs2_value, rs2_tag
  );

  modport slave (
    input  rd_en, rs1_addr, rs2_addr,
    input  alloc, alloc_dst_reg, alloc_tag,
    input  retiring, retiring_dst_reg, retiring_tag, retiring_value,
    input  incoming_en, incoming_tag, incoming_value, flush,
    output rs1_ready, rs1_value, rs1_tag, rs2_ready, rs2_value, rs2_tag
  );
endinterface

// File: rtl/regstat_rf.sv
// Architectural register file with per-register rename status (pending bit + producer ROB tag).
// Define ZERO_REG_EN to make register 0 a hardwired zero that ignores alloc and retire.
module regstat_rf #(
  parameter int DATAW    = 32,
  parameter int REGADDRW = 5,
  parameter int TAGW     = 6
) (
  input logic         clk,
  input logic         rst_n,
  regstat_rf_if.slave rf_if
);
  localparam int REGCOUNT = 1 << REGADDRW;
`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATAW-1:0]    rf_reg   [REGCOUNT];
  logic [TAGW-1:0]     ptag_reg [REGCOUNT];
  logic [REGCOUNT-1:0] pend_reg;

  logic [REGCOUNT-1:0] alloc_hit;
  logic [REGCOUNT-1:0] ret_hit;

  // Flush cancels a same-cycle rename but never the committed write.
  generate
    for (genvar gi = 0; gi < REGCOUNT; gi++) begin : g_dec
      localparam bit IS_ZERO = ZERO_REG && (gi == 0);
      assign alloc_hit[gi] = rf_if.alloc && !rf_if.flush && !IS_ZERO &&
                             !rf_if.alloc_dst_reg[REGADDRW] &&
                             (rf_if.alloc_dst_reg[REGADDRW-1:0] == REGADDRW'(gi));
      assign ret_hit[gi]   = rf_if.retiring && !IS_ZERO &&
                             !rf_if.retiring_dst_reg[REGADDRW] &&
                             (rf_if.retiring_dst_reg[REGADDRW-1:0] == REGADDRW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      for (int i = 0; i < REGCOUNT; i++) begin
        rf_reg[i]   <= '0;
        ptag_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REGCOUNT; i++) begin
        if (ret_hit[i]) begin
          rf_reg[i] <= rf_if.retiring_value;
        end
        if (rf_if.flush) begin
          pend_reg[i] <= 1'b0;
        end else if (alloc_hit[i]) begin
          pend_reg[i] <= 1'b1;
          ptag_reg[i] <= rf_if.alloc_tag;
        end else if (ret_hit[i] && (ptag_reg[i] == rf_if.retiring_tag)) begin
          pend_reg[i] <= 1'b0;
        end
      end
    end
  end

  logic [REGADDRW-1:0] src_addr [2];
  assign src_addr[0] = rf_if.rs1_addr;
  assign src_addr[1] = rf_if.rs2_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic             ready_next;
      logic [DATAW-1:0] value_next;
      logic [TAGW-1:0]  tag_next;
      logic             ready_reg;
      logic [DATAW-1:0] value_reg;
      logic [TAGW-1:0]  tag_reg;
      logic             pend_sel;
      logic [TAGW-1:0]  ptag_sel;

      assign pend_sel = pend_reg[src_addr[gi]];
      assign ptag_sel = ptag_reg[src_addr[gi]];

      // Uses pre-edge state, so an instruction renaming its own source sees the old mapping.
      always_comb begin
        ready_next = 1'b0;
        value_next = '0;
        tag_next   = '0;
        if (rf_if.rd_en) begin
          if (ZERO_REG && (src_addr[gi] == '0)) begin
            ready_next = 1'b1;
          end else if (pend_sel && rf_if.incoming_en && (rf_if.incoming_tag == ptag_sel)) begin
            ready_next = 1'b1;
            value_next = rf_if.incoming_value;
          end else if (pend_sel && rf_if.retiring && (rf_if.retiring_tag == ptag_sel)) begin
            ready_next = 1'b1;
            value_next = rf_if.retiring_value;
          end else if (pend_sel) begin
            tag_next = ptag_sel;
          end else begin
            ready_next = 1'b1;
            value_next = rf_reg[src_addr[gi]];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ready_reg <= 1'b0;
          value_reg <= '0;
          tag_reg   <= '0;
        end else begin
          ready_reg <= ready_next;
          value_reg <= value_next;
          tag_reg   <= tag_next;
        end
      end
    end
  endgenerate

  assign rf_if.rs1_ready = g_src[0].ready_reg;
  assign rf_if.rs1_value = g_src[0].value_reg;
  assign rf_if.rs1_tag   = g_src[0].tag_reg;
  assign rf_if.rs2_ready = g_src[1].ready_reg;
  assign rf_if.rs2_value = g_src[1].value_reg;
  assign rf_if.rs2_tag   = g_src[1].tag_reg;
endmodule

// File: tb/tb_regstat_rf.sv
// Vector-table bench for regstat_rf: each row is one cycle of stimulus plus the lookup result
// expected on the following cycle, queued when driven and compared after the clock edge.
module tb_regstat_rf;
  localparam int DATAW    = 32;
  localparam int REGADDRW = 5;
  localparam int TAGW     = 6;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  typedef struct packed {
    logic             r1;
    logic [DATAW-1:0] v1;
    logic [TAGW-1:0]  t1;
    logic             r2;
    logic [DATAW-1:0] v2;
    logic [TAGW-1:0]  t2;
  } exp_t;

  typedef struct {
    logic                rd;
    logic [REGADDRW-1:0] a1, a2;
    logic                al;
    logic [REGADDRW:0]   adst;
    logic [TAGW-1:0]     atag;
    logic                rt;
    logic [REGADDRW:0]   rdst;
    logic [TAGW-1:0]     rtag;
    logic [DATAW-1:0]    rval;
    logic                ie;
    logic [TAGW-1:0]     itag;
    logic [DATAW-1:0]    ival;
    logic                fl;
    exp_t                e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regstat_rf_if #(.DATAW(DATAW), .REGADDRW(REGADDRW), .TAGW(TAGW)) bus ();

  regstat_rf #(.DATAW(DATAW), .REGADDRW(REGADDRW), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf_if (bus)
  );

  int   checks = 0;
  int   passed = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  function automatic vec_t mk(bit rd, int a1, int a2, bit al, int adst, int atag,
                              bit rt, int rdst, int rtag, int rval, bit ie, int itag, int ival,
                              bit fl, bit r1, int v1, int t1, bit r2, int v2, int t2);
    vec_t v;
    v.rd = rd; v.a1 = a1[REGADDRW-1:0]; v.a2 = a2[REGADDRW-1:0];
    v.al = al; v.adst = adst[REGADDRW:0]; v.atag = atag[TAGW-1:0];
    v.rt = rt; v.rdst = rdst[REGADDRW:0]; v.rtag = rtag[TAGW-1:0]; v.rval = rval;
    v.ie = ie; v.itag = itag[TAGW-1:0]; v.ival = ival; v.fl = fl;
    v.e = '{r1: r1, v1: v1, t1: t1[TAGW-1:0], r2: r2, v2: v2, t2: t2[TAGW-1:0]};
    return v;
  endfunction

  task automatic compare(string name, exp_t exp);
    exp_t got;
    got = '{r1: bus.rs1_ready, v1: bus.rs1_value, t1: bus.rs1_tag,
            r2: bus.rs2_ready, v2: bus.rs2_value, t2: bus.rs2_tag};
    checks++;
    if (got === exp) begin
      passed++;
      $display("%s ok: rs1 r=%0b v=%h t=%0d rs2 r=%0b v=%h t=%0d",
               name, got.r1, got.v1, got.t1, got.r2, got.v2, got.t2);
    end else begin
      $display("FAIL %s: got rs1 r=%0b v=%h t=%0d rs2 r=%0b v=%h t=%0d, want rs1 r=%0b v=%h t=%0d rs2 r=%0b v=%h t=%0d",
               name, got.r1, got.v1, got.t1, got.r2, got.v2, got.t2,
               exp.r1, exp.v1, exp.t1, exp.r2, exp.v2, exp.t2);
    end
  endtask

  task automatic drive(vec_t v);
    bus.rd_en = v.rd; bus.rs1_addr = v.a1; bus.rs2_addr = v.a2;
    bus.alloc = v.al; bus.alloc_dst_reg = v.adst; bus.alloc_tag = v.atag;
    bus.retiring = v.rt; bus.retiring_dst_reg = v.rdst;
    bus.retiring_tag = v.rtag; bus.retiring_value = v.rval;
    bus.incoming_en = v.ie; bus.incoming_tag = v.itag; bus.incoming_value = v.ival;
    bus.flush = v.fl;
  endtask

  task automatic step(string name, vec_t v);
    exp_t exp;
    drive(v);
    sb_q.push_back(v.e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      $display("FAIL %s: scoreboard empty, want 1 entry", name);
    end else begin
      exp = sb_q.pop_front();
      compare(name, exp);
    end
  endtask

  initial begin
    exp_t zero_e;
    vec_t idle;
    zero_e = '0;
    idle = mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0, 0,0,0, 0,0,0);
    drive(idle);

    //   rd a1 a2  al adst atag  rt rdst rtag rval      ie itag ival   fl  r1 v1 t1  r2 v2 t2
    vecs.push_back(mk(1, 3, 7,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  1, 0, 0,  1, 0, 0));
    vecs.push_back(mk(1, 5, 5,  1, 5, 9,   0, 0, 0, 0,          0, 0, 0,      0,  1, 0, 0,  1, 0, 0));
    vecs.push_back(mk(1, 5, 0,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  0, 0, 9,  1, 0, 0));
    vecs.push_back(mk(1, 5, 3,  0, 0, 0,   1, 5, 9, 'h1234,     0, 0, 0,      0,  1, 'h1234, 0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 5,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  1, 'h1234, 0, 1, 'h1234, 0));
    vecs.push_back(mk(1, 4, 4,  1, 4, 12,  0, 0, 0, 0,          0, 0, 0,      0,  1, 0, 0,  1, 0, 0));
    vecs.push_back(mk(1, 4, 4,  0, 0, 0,   0, 0, 0, 0,          1, 12, 'hAB,  0,  1, 'hAB, 0, 1, 'hAB, 0));
    vecs.push_back(mk(1, 4, 5,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  0, 0, 12, 1, 'h1234, 0));
    vecs.push_back(mk(1, 4, 5,  0, 0, 0,   1, 4, 12, 'h55,      1, 12, 'hAB,  0,  1, 'hAB, 0, 1, 'h1234, 0));
    vecs.push_back(mk(1, 4, 4,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  1, 'h55, 0, 1, 'h55, 0));
    vecs.push_back(mk(0, 5, 4,  1, 6, 1,   0, 0, 0, 0,          0, 0, 0,      0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 6, 2,   0, 0, 0, 0,          0, 0, 0,      0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 6, 6,  0, 0, 0,   1, 6, 1, 7,          0, 0, 0,      0,  0, 0, 2,  0, 0, 2));
    vecs.push_back(mk(1, 6, 5,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  0, 0, 2,  1, 'h1234, 0));
    vecs.push_back(mk(1, 6, 6,  0, 0, 0,   0, 0, 0, 0,          1, 2, 'h99,   0,  1, 'h99, 0, 1, 'h99, 0));
    vecs.push_back(mk(1, 6, 6,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      1,  0, 0, 2,  0, 0, 2));
    vecs.push_back(mk(1, 6, 4,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  1, 7, 0,  1, 'h55, 0));
    vecs.push_back(mk(0, 0, 0,  1, 8, 3,   0, 0, 0, 0,          0, 0, 0,      1,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 8, 8,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  1, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,   1, 9, 0, 'hCAFE,     0, 0, 0,      0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 9, 4,   0, 0, 0, 0,          0, 0, 0,      0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 9, 9,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      1,  0, 0, 4,  0, 0, 4));
    vecs.push_back(mk(1, 9, 8,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  1, 'hCAFE, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 10, 7,  0, 0, 0, 0,          0, 0, 0,      0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 10, 8,  1, 10, 7, 'h10,      0, 0, 0,      0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 10, 10, 0, 0, 0,  0, 0, 0, 0,          0, 0, 0,      0,  0, 0, 8,  0, 0, 8));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      1,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 10, 10, 0, 0, 0,  0, 0, 0, 0,          0, 0, 0,      0,  1, 'h10, 0, 1, 'h10, 0));
    vecs.push_back(mk(0, 0, 0,  1, 35, 30, 1, 35, 0, 'hDEAD,    0, 0, 0,      0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 3, 3,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  1, 0, 0,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  1, 0, 5,   0, 0, 0, 0,          0, 0, 0,      0,  1, 0, 0,  1, 0, 0));
    vecs.push_back(mk(1, 0, 7,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  ZR, 0, ZR ? 0 : 5, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0, 0,   1, 0, 5, 'hFF,       0, 0, 0,      0,  1, ZR ? 0 : 'hFF, 0, 1, ZR ? 0 : 'hFF, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0, 0,   0, 0, 0, 0,          0, 0, 0,      0,  1, ZR ? 0 : 'hFF, 0, 1, ZR ? 0 : 'hFF, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    compare("reset_outputs", zero_e);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset arriving mid-cycle must clear outputs at once and drop all renames.
    step("pre_reset_read", mk(1, 5, 4, 1, 11, 9, 0, 0, 0, 0, 0, 0, 0, 0,
                              1, 'h1234, 0, 1, 'h55, 0));
    drive(idle);
    #2 rst_n = 1'b0;
    #1 compare("async_reset_outputs", zero_e);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_r5_r11", mk(1, 5, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                 1, 0, 0, 1, 0, 0));

    if (sb_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
